// File: rtl/tq_ram_1p_arb.sv
// Round-robin arbiter with optional burst locking.
// Shares one single-port TQ SRAM between a writer (port A) and a reader (port B).
module tq_ram_1p_arb #(
    parameter int unsigned Word_Width = 16,
    parameter int unsigned Addr_Width = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req_i,
    input  logic                  a_lock_i,
    input  logic                  a_wen_i,
    input  logic [Addr_Width-1:0] a_addr_i,
    input  logic [Word_Width-1:0] a_data_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    input  logic                  b_req_i,
    input  logic                  b_lock_i,
    input  logic                  b_wen_i,
    input  logic [Addr_Width-1:0] b_addr_i,
    input  logic [Word_Width-1:0] b_data_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [Word_Width-1:0] rdata_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    output logic [Word_Width-1:0] ram_data_o,
    input  logic [Word_Width-1:0] ram_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;   // 0 = A, 1 = B
    logic                  a_gnt, b_gnt;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [Addr_Width-1:0] addr_q;
    logic [Word_Width-1:0] data_q;

    // Grant decision and next state; grants are combinational with the request
    always_comb begin
        state_d = state_q;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req_i && (!b_req_i || last_gnt_q)) begin
                    a_gnt = 1'b1;
                end else if (b_req_i) begin
                    b_gnt = 1'b1;
                end
                if (a_gnt && a_lock_i) begin
                    state_d = OWN_A;
                end else if (b_gnt && b_lock_i) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                a_gnt = a_req_i;
                if (!a_req_i || !a_lock_i) begin
                    state_d = IDLE;
                end
            end
            OWN_B: begin
                b_gnt = b_req_i;
                if (!b_req_i || !b_lock_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
        last_gnt_d = a_gnt ? 1'b0 : (b_gnt ? 1'b1 : last_gnt_q);
    end

    // State, fairness pointer, read-valid pipeline and held RAM address/data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            a_rvalid_q <= a_gnt && a_wen_i;
            b_rvalid_q <= b_gnt && b_wen_i;
            addr_q     <= ram_addr_o;
            data_q     <= ram_data_o;
        end
    end

    // Idle cycles keep address/data at their last driven values to limit toggling
    always_comb begin
        ram_cen_o  = !(a_gnt || b_gnt);
        ram_wen_o  = 1'b1;
        ram_addr_o = addr_q;
        ram_data_o = data_q;
        if (a_gnt) begin
            ram_wen_o  = a_wen_i;
            ram_addr_o = a_addr_i;
            ram_data_o = a_data_i;
        end else if (b_gnt) begin
            ram_wen_o  = b_wen_i;
            ram_addr_o = b_addr_i;
            ram_data_o = b_data_i;
        end
        if (!rst_n) begin
            ram_addr_o = '0;
            ram_data_o = '0;
        end
    end

    assign ram_oen_o  = 1'b0;
    assign a_gnt_o    = a_gnt;
    assign b_gnt_o    = b_gnt;
    assign a_rvalid_o = a_rvalid_q && rst_n;
    assign b_rvalid_o = b_rvalid_q && rst_n;
    assign rdata_o    = ram_data_i;

endmodule

// File: tb/tb_tq_ram_1p_arb.sv
// Directed bench for tq_ram_1p_arb with a small behavioural SRAM behind it.
module tb_tq_ram_1p_arb;

    localparam int unsigned WW = 16;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_lock, a_wen, b_req, b_lock, b_wen;
    logic [AW-1:0] a_addr, b_addr;
    logic [WW-1:0] a_data, b_data;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [WW-1:0] rdata;
    logic          ram_cen, ram_oen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata, ram_rdata;

    logic [WW-1:0] mem [32];

    int vec_cnt  = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    tq_ram_1p_arb #(.Word_Width(WW), .Addr_Width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req), .a_lock_i(a_lock), .a_wen_i(a_wen),
        .a_addr_i(a_addr), .a_data_i(a_data),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
        .b_req_i(b_req), .b_lock_i(b_lock), .b_wen_i(b_wen),
        .b_addr_i(b_addr), .b_data_i(b_data),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
        .rdata_o(rdata),
        .ram_cen_o(ram_cen), .ram_oen_o(ram_oen), .ram_wen_o(ram_wen),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
    );

    // SRAM model: write on cen=0/wen=0, read data one cycle after cen=0/wen=1
    always_ff @(posedge clk) begin
        if (!ram_cen && !ram_wen) mem[ram_addr] <= ram_wdata;
        if (!ram_cen && ram_wen)  ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ram_rdata = '0;
        rst_n = 1'b0;
        a_req = 1'b1; a_lock = 1'b0; a_wen = 1'b1; a_addr = 5'd3; a_data = '0;
        b_req = 1'b1; b_lock = 1'b0; b_wen = 1'b1; b_addr = 5'd7; b_data = '0;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_a_gnt", 32'(a_gnt), 32'd0);
            check("rst_b_gnt", 32'(b_gnt), 32'd0);
            check("rst_cen", 32'(ram_cen), 32'd1);
            check("rst_wen", 32'(ram_wen), 32'd1);
            check("rst_oen", 32'(ram_oen), 32'd0);
            check("rst_addr", 32'(ram_addr), 32'd0);
            check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
            next_cycle();
        end
        rst_n = 1'b1;

        // Tie fairness: A,B,A,B,A,B; rvalid follows previous winner
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("tie_a_gnt", 32'(a_gnt), 32'((i % 2) == 0));
            check("tie_b_gnt", 32'(b_gnt), 32'((i % 2) == 1));
            check("tie_addr", 32'(ram_addr), (i % 2) == 0 ? 32'd3 : 32'd7);
            check("tie_cen", 32'(ram_cen), 32'd0);
            check("tie_a_rvalid", 32'(a_rvalid), 32'(i > 0 && (i % 2) == 1));
            check("tie_b_rvalid", 32'(b_rvalid), 32'(i > 0 && (i % 2) == 0));
            next_cycle();
        end

        // Idle: address holds, controls deasserted
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("idle_cen", 32'(ram_cen), 32'd1);
        check("idle_wen", 32'(ram_wen), 32'd1);
        check("idle_addr_hold", 32'(ram_addr), 32'd7);
        check("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        next_cycle();

        // A writes 0x1234 to address 5
        a_req = 1'b1; a_wen = 1'b0; a_addr = 5'd5; a_data = 16'h1234;
        @(negedge clk);
        check("wr_a_gnt", 32'(a_gnt), 32'd1);
        check("wr_wen", 32'(ram_wen), 32'd0);
        check("wr_addr", 32'(ram_addr), 32'd5);
        check("wr_data", 32'(ram_wdata), 32'h1234);
        next_cycle();

        // B reads address 5
        a_req = 1'b0; b_req = 1'b1; b_wen = 1'b1; b_addr = 5'd5;
        @(negedge clk);
        check("rd_b_gnt", 32'(b_gnt), 32'd1);
        check("rd_wen", 32'(ram_wen), 32'd1);
        check("wr_no_rvalid", 32'(a_rvalid), 32'd0);
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        check("rd_b_rvalid", 32'(b_rvalid), 32'd1);
        check("rd_rdata", 32'(rdata), 32'h1234);
        check("rd_a_rvalid", 32'(a_rvalid), 32'd0);
        next_cycle();

        // Locked burst: A writes 0..31 while B requests throughout
        b_req = 1'b1; b_addr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            a_req = 1'b1; a_lock = (i != 31); a_wen = 1'b0;
            a_addr = AW'(i); a_data = WW'(16'h0010 + i);
            @(negedge clk);
            check("burst_a_gnt", 32'(a_gnt), 32'd1);
            check("burst_b_gnt", 32'(b_gnt), 32'd0);
            check("burst_addr", 32'(ram_addr), 32'(i));
            next_cycle();
        end
        a_req = 1'b0; a_lock = 1'b0;

        // Back-to-back B reads of 0,1,2 (first grant is the post-burst cycle)
        for (int i = 0; i < 4; i++) begin
            b_req = (i < 3); b_addr = AW'(i);
            @(negedge clk);
            if (i < 3) check("b2b_b_gnt", 32'(b_gnt), 32'd1);
            check("b2b_b_rvalid", 32'(b_rvalid), 32'(i > 0));
            if (i > 0) check("b2b_rdata", 32'(rdata), 32'(16'h0010 + i - 1));
            next_cycle();
        end

        // Lock without request in IDLE does nothing
        a_lock = 1'b1; b_req = 1'b1; b_lock = 1'b0; b_addr = 5'd9;
        @(negedge clk);
        check("lock_noreq_b_gnt", 32'(b_gnt), 32'd1);
        next_cycle();
        a_lock = 1'b0; b_req = 1'b0;
        next_cycle();

        // B locked read, then reset in the following cycle
        b_req = 1'b1; b_lock = 1'b1; b_wen = 1'b1; b_addr = 5'd1;
        @(negedge clk);
        check("own_b_gnt", 32'(b_gnt), 32'd1);
        next_cycle();
        rst_n = 1'b0; a_req = 1'b1; a_wen = 1'b1; a_addr = 5'd2;
        @(negedge clk);
        check("midrst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("midrst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check("midrst_cen", 32'(ram_cen), 32'd1);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_a_gnt", 32'(a_gnt), 32'd1);
        check("postrst_b_gnt", 32'(b_gnt), 32'd0);
        check("postrst_b_rvalid", 32'(b_rvalid), 32'd0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/tq_ram_1p_arb.md
Name: tq_ram_1p_arb

Overview:
- Two-requester arbiter that shares one single-port 16x32 TQ SRAM between a writer (transform output, port A) and a reader (quantisation input, port B).
- Round-robin arbitration with optional burst locking; drives the SRAM's active-low cen/oen/wen controls.
- Returns read data with a per-requester valid strobe.
- Sits between the TQ datapath stages and the SRAM instance.

Parameters:
- Word_Width, 16, SRAM data width in bits
- Addr_Width, 5, SRAM address width in bits (32 words)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- a_req_i  input  1  requester A access request
- a_lock_i  input  1  A holds ownership after grant while high
- a_wen_i  input  1  A access type (0 write, 1 read)
- a_addr_i  input  Addr_Width  A address
- a_data_i  input  Word_Width  A write data
- a_gnt_o  output  1  A access performed this cycle
- a_rvalid_o  output  1  A read data valid
- b_req_i, b_lock_i, b_wen_i, b_addr_i, b_data_i, b_gnt_o, b_rvalid_o  same as A, for requester B
- rdata_o  output  Word_Width  read data to both requesters; qualify with a_rvalid_o or b_rvalid_o
- ram_cen_o  output  1  SRAM chip enable, active low
- ram_oen_o  output  1  SRAM output enable, active low
- ram_wen_o  output  1  SRAM write enable, active low
- ram_addr_o  output  Addr_Width  SRAM address
- ram_data_o  output  Word_Width  SRAM write data
- ram_data_i  input  Word_Width  SRAM read data, valid one cycle after a read access

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low, and sampled on the rising edge.
- Reset state, registered: state=IDLE, last_gnt=B (so A wins the first tie), rvalid pipeline cleared.
- Outputs while rst_n=0: a_gnt_o=b_gnt_o=0, a_rvalid_o=b_rvalid_o=0, ram_cen_o=1, ram_wen_o=1, ram_oen_o=0, ram_addr_o=0, ram_data_o=0.
- State machine: IDLE, OWN_A, OWN_B.
- IDLE:
  - Grant is combinational in the same cycle as the request.
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the requester not equal to last_gnt.
  - Granted requester has lock=1: go to OWN_x. Otherwise stay in IDLE.
- OWN_A:
  - Only A can be granted; b_req_i is ignored.
  - a_gnt_o = a_req_i.
  - Exit to IDLE on the first cycle where a_lock_i=0 or a_req_i=0. That cycle's access is still performed if a_req_i=1.
  - B is not granted in the exit cycle; B arbitration resumes the next cycle.
- OWN_B: symmetric to OWN_A.
- last_gnt updates to the granted requester on every cycle with a grant.
- Granted cycle RAM drive: ram_cen_o=0, ram_wen_o = winner's wen_i, ram_addr_o/ram_data_o = winner's inputs.
- No grant: ram_cen_o=1, ram_wen_o=1. Address and data hold their last driven values to limit toggling.
- ram_oen_o is tied 0.
- Read latency:
  - A granted read in cycle N raises x_rvalid_o in cycle N+1, with rdata_o = ram_data_i.
  - rvalid is a 1-cycle pulse per granted read.
  - Writes never produce rvalid.
  - Back-to-back reads give a continuous rvalid stream.
- Switchover: A read granted in cycle N and a B access granted in N+1 are legal. a_rvalid_o in N+1 is unaffected by B's grant.
- Requesters hold req/addr/data until they see gnt. A request is consumed only in a cycle with gnt=1.
- Reset mid-burst: the next cycle returns to IDLE, an outstanding rvalid is dropped, and last_gnt=B.
- Lock asserted without req has no effect in IDLE.
- Address wraps naturally at the 5-bit width; there is no range check.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with both req=1 -> no gnt, ram_cen_o=1, no rvalid. First cycle after reset release -> a_gnt_o=1.
- Tie fairness: both request continuously, no lock, for 6 cycles -> grants alternate A,B,A,B,A,B. ram_addr_o follows the winner's address.
- Write then read: A writes 0x1234 to address 5. Then B reads address 5 in cycle N -> b_rvalid_o=1 and rdata_o=0x1234 in N+1. a_rvalid_o stays 0.
- Burst lock: A asserts lock and writes addresses 0..31 over 32 cycles while B requests throughout -> b_gnt_o=0 for all 32 cycles. A drops lock on address 31 -> b_gnt_o=1 on the following cycle.
- Back-to-back reads: B reads addresses 0,1,2 (preloaded 0x0010,0x0011,0x0012) -> b_rvalid_o high for 3 consecutive cycles with rdata_o=0x0010,0x0011,0x0012.
- Reset mid-operation: pulse rst_n=0 during an OWN_B burst in the cycle after a B read grant -> b_rvalid_o=0 next cycle. After release, with both requesting, A is granted first.
